// File: rtl/alu_pkg.sv
// Shared constants and decoded-control type for the ID/EX issue stage.
package alu_pkg;

   // ALU operation encodings seen by the EX-stage ALU
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SLL  = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SR   = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b111;

   // RV32I major opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {In1Rs1, In1Pc, In1Zero} in1_sel_e;
   typedef enum logic [1:0] {In2Rs2, In2Imm, In2Four} in2_sel_e;

   typedef struct packed {
      logic       legal;     // recognised instruction; otherwise issued as a bubble
      logic       uses_rs1;
      logic       uses_rs2;
      logic [2:0] aluop;
      logic       invert;
      logic       regwrite;  // before the rd==x0 override
      logic       memread;
      logic       memwrite;
      logic       branch;
      logic [2:0] funct3;
      in1_sel_e   in1_sel;
      in2_sel_e   in2_sel;
   } idex_ctrl_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode into ALU control, operand selects and immediate.
module alu_decode
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     instr,
   output idex_ctrl_t      ctrl,
   output logic [XLEN-1:0] imm
);

   logic [2:0]      f3;
   logic [XLEN-1:0] imm_i, imm_s, imm_u;

   assign f3    = instr[14:12];
   assign imm_i = XLEN'($signed(instr[31:20]));
   assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
   assign imm_u = XLEN'($signed({instr[31:12], 12'h000}));

   // Opcode decode; anything unrecognised leaves ctrl all-zero (legal=0)
   always_comb begin
      ctrl = '0;
      imm  = '0;
      case (instr[6:0])
         OP_R: begin
            ctrl.legal    = 1'b1;
            ctrl.uses_rs1 = 1'b1;
            ctrl.uses_rs2 = 1'b1;
            ctrl.aluop    = f3;
            ctrl.invert   = instr[30] && (f3 == ALU_ADD || f3 == ALU_SR);
            ctrl.regwrite = 1'b1;
            ctrl.funct3   = f3;
         end
         OP_I: begin
            ctrl.legal    = 1'b1;
            ctrl.uses_rs1 = 1'b1;
            ctrl.aluop    = f3;
            // bit 30 is immediate data for ADDI, so only SRAI may invert
            ctrl.invert   = instr[30] && (f3 == ALU_SR);
            ctrl.regwrite = 1'b1;
            ctrl.funct3   = f3;
            ctrl.in2_sel  = In2Imm;
            imm           = imm_i;
         end
         OP_LOAD: begin
            ctrl.legal    = 1'b1;
            ctrl.uses_rs1 = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.memread  = 1'b1;
            ctrl.funct3   = f3;
            ctrl.in2_sel  = In2Imm;
            imm           = imm_i;
         end
         OP_STORE: begin
            ctrl.legal    = 1'b1;
            ctrl.uses_rs1 = 1'b1;
            ctrl.uses_rs2 = 1'b1;
            ctrl.memwrite = 1'b1;
            ctrl.funct3   = f3;
            ctrl.in2_sel  = In2Imm;
            imm           = imm_s;
         end
         OP_BRANCH: begin
            // funct3 01x has no branch; leave it illegal
            if (f3[2:1] != 2'b01) begin
               ctrl.legal    = 1'b1;
               ctrl.uses_rs1 = 1'b1;
               ctrl.uses_rs2 = 1'b1;
               ctrl.branch   = 1'b1;
               ctrl.funct3   = f3;
               ctrl.aluop    = !f3[2] ? ALU_ADD : (f3[1] ? ALU_SLTU : ALU_SLT);
               ctrl.invert   = !f3[2];  // BEQ/BNE compare via subtract
            end
         end
         OP_LUI: begin
            ctrl.legal    = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.in1_sel  = In1Zero;
            ctrl.in2_sel  = In2Imm;
            imm           = imm_u;
         end
         OP_AUIPC: begin
            ctrl.legal    = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.in1_sel  = In1Pc;
            ctrl.in2_sel  = In2Imm;
            imm           = imm_u;
         end
         OP_JAL: begin
            ctrl.legal    = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.in1_sel  = In1Pc;
            ctrl.in2_sel  = In2Four;
         end
         OP_JALR: begin
            ctrl.legal    = 1'b1;
            ctrl.uses_rs1 = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.funct3   = f3;
            ctrl.in1_sel  = In1Pc;
            ctrl.in2_sel  = In2Four;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, operand forwarding, load-use stall and ID/EX register.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter logic [31:0] RESET_PC_NOP = 32'h00000013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [31:0]     id_instr,
   input  logic [31:0]     id_pc,
   input  logic [XLEN-1:0] rf_rs1_data,
   input  logic [XLEN-1:0] rf_rs2_data,
   input  logic            exm_regwrite,
   input  logic [4:0]      exm_rd,
   input  logic [XLEN-1:0] exm_result,
   input  logic            mwb_regwrite,
   input  logic [4:0]      mwb_rd,
   input  logic [XLEN-1:0] mwb_result,
   input  logic            flush,
   output logic            stall,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_alu_in1,
   output logic [XLEN-1:0] ex_alu_in2,
   output logic [2:0]      ex_aluop,
   output logic            ex_invert,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [4:0]      ex_rd,
   output logic            ex_regwrite,
   output logic            ex_memread,
   output logic            ex_memwrite,
   output logic            ex_branch,
   output logic [2:0]      ex_funct3,
   output logic [31:0]     ex_pc
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] in1;
      logic [XLEN-1:0] in2;
      logic [XLEN-1:0] rs2_data;
      logic [4:0]      rd;
      logic [31:0]     pc;
      logic [2:0]      aluop;
      logic            invert;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
      logic            branch;
      logic [2:0]      funct3;
   } idex_t;

   idex_ctrl_t      ctrl;
   logic [XLEN-1:0] imm;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] rs1_fwd, rs2_fwd;
   logic            load_use, issue;
   idex_t           ex_d, ex_q;

   assign rs1 = id_instr[19:15];
   assign rs2 = id_instr[24:20];
   assign rd  = id_instr[11:7];

   alu_decode #(
      .XLEN(XLEN)
   ) u_decode (
      .instr(id_instr),
      .ctrl (ctrl),
      .imm  (imm)
   );

   // Operand forwarding: x0 is hard zero, youngest producer (EX/MEM) wins
   always_comb begin
      rs1_fwd = rf_rs1_data;
      if (rs1 == 5'd0)                          rs1_fwd = '0;
      else if (exm_regwrite && exm_rd == rs1)   rs1_fwd = exm_result;
      else if (mwb_regwrite && mwb_rd == rs1)   rs1_fwd = mwb_result;
      rs2_fwd = rf_rs2_data;
      if (rs2 == 5'd0)                          rs2_fwd = '0;
      else if (exm_regwrite && exm_rd == rs2)   rs2_fwd = exm_result;
      else if (mwb_regwrite && mwb_rd == rs2)   rs2_fwd = mwb_result;
   end

   // A load in EX cannot forward yet; hold IF/ID one cycle if its rd is consumed
   assign load_use = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
                     ((ctrl.uses_rs1 && rs1 == ex_q.rd) || (ctrl.uses_rs2 && rs2 == ex_q.rd));
   assign stall    = id_valid && load_use && !flush && !reset;
   assign issue    = id_valid && ctrl.legal && (id_instr != RESET_PC_NOP) && !stall && !flush;

   // Next ID/EX contents; every non-issue case becomes an all-zero bubble
   always_comb begin
      ex_d = '0;
      if (issue) begin
         ex_d.valid = 1'b1;
         case (ctrl.in1_sel)
            In1Rs1:  ex_d.in1 = rs1_fwd;
            In1Pc:   ex_d.in1 = XLEN'(id_pc);
            default: ex_d.in1 = '0;
         endcase
         case (ctrl.in2_sel)
            In2Rs2:  ex_d.in2 = rs2_fwd;
            In2Imm:  ex_d.in2 = imm;
            In2Four: ex_d.in2 = XLEN'(4);
            default: ex_d.in2 = '0;
         endcase
         ex_d.rs2_data = ctrl.uses_rs2 ? rs2_fwd : '0;
         ex_d.rd       = ctrl.regwrite ? rd : 5'd0;
         ex_d.regwrite = ctrl.regwrite && (rd != 5'd0);
         ex_d.pc       = id_pc;
         ex_d.aluop    = ctrl.aluop;
         ex_d.invert   = ctrl.invert;
         ex_d.memread  = ctrl.memread;
         ex_d.memwrite = ctrl.memwrite;
         ex_d.branch   = ctrl.branch;
         ex_d.funct3   = ctrl.funct3;
      end
   end

   // ID/EX pipeline register with synchronous clear
   always_ff @(posedge clk) begin
      if (reset) ex_q <= '0;
      else       ex_q <= ex_d;
   end

   assign ex_valid    = ex_q.valid;
   assign ex_alu_in1  = ex_q.in1;
   assign ex_alu_in2  = ex_q.in2;
   assign ex_aluop    = ex_q.aluop;
   assign ex_invert   = ex_q.invert;
   assign ex_rs2_data = ex_q.rs2_data;
   assign ex_rd       = ex_q.rd;
   assign ex_regwrite = ex_q.regwrite;
   assign ex_memread  = ex_q.memread;
   assign ex_memwrite = ex_q.memwrite;
   assign ex_branch   = ex_q.branch;
   assign ex_funct3   = ex_q.funct3;
   assign ex_pc       = ex_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed table, hazard sequences, random vs model.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_instr, id_pc, rf_rs1_data, rf_rs2_data;
   logic        exm_regwrite, mwb_regwrite, flush;
   logic [4:0]  exm_rd, mwb_rd;
   logic [31:0] exm_result, mwb_result;
   logic        stall, ex_valid, ex_invert, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
   logic [31:0] ex_alu_in1, ex_alu_in2, ex_rs2_data, ex_pc;
   logic [2:0]  ex_aluop, ex_funct3;
   logic [4:0]  ex_rd;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk         (clk),
      .reset       (reset),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .rf_rs1_data (rf_rs1_data),
      .rf_rs2_data (rf_rs2_data),
      .exm_regwrite(exm_regwrite),
      .exm_rd      (exm_rd),
      .exm_result  (exm_result),
      .mwb_regwrite(mwb_regwrite),
      .mwb_rd      (mwb_rd),
      .mwb_result  (mwb_result),
      .flush       (flush),
      .stall       (stall),
      .ex_valid    (ex_valid),
      .ex_alu_in1  (ex_alu_in1),
      .ex_alu_in2  (ex_alu_in2),
      .ex_aluop    (ex_aluop),
      .ex_invert   (ex_invert),
      .ex_rs2_data (ex_rs2_data),
      .ex_rd       (ex_rd),
      .ex_regwrite (ex_regwrite),
      .ex_memread  (ex_memread),
      .ex_memwrite (ex_memwrite),
      .ex_branch   (ex_branch),
      .ex_funct3   (ex_funct3),
      .ex_pc       (ex_pc)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [2:0]  aluop;
      logic        invert;
      logic [31:0] rs2_data;
      logic [4:0]  rd;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        branch;
      logic [2:0]  funct3;
      logic [31:0] pc;
   } obs_t;

   typedef struct {
      logic        idv;
      logic [31:0] instr, pc, r1, r2;
      logic        exm_we;
      logic [4:0]  exm_rd;
      logic [31:0] exm_res;
      logic        mwb_we;
      logic [4:0]  mwb_rd;
      logic [31:0] mwb_res;
      logic        flush;
   } stim_t;

   typedef struct {
      string name;
      stim_t s;
      obs_t  e;
   } vec_t;

   localparam logic [31:0] NOP = 32'h00000013;

   int   total = 0;
   int   bad   = 0;
   obs_t mdl_ex = '0;  // model's view of what sits in ID/EX

   function automatic stim_t mks(logic idv, logic [31:0] instr, logic [31:0] pc,
                                 logic [31:0] r1, logic [31:0] r2,
                                 logic xw, logic [4:0] xrd, logic [31:0] xres,
                                 logic ww, logic [4:0] wrd, logic [31:0] wres, logic fl);
      stim_t s;
      s.idv = idv; s.instr = instr; s.pc = pc; s.r1 = r1; s.r2 = r2;
      s.exm_we = xw; s.exm_rd = xrd; s.exm_res = xres;
      s.mwb_we = ww; s.mwb_rd = wrd; s.mwb_res = wres; s.flush = fl;
      return s;
   endfunction

   function automatic obs_t mko(logic v, logic [31:0] in1, logic [31:0] in2, logic [2:0] op,
                                logic inv, logic [31:0] r2d, logic [4:0] rd, logic rw,
                                logic mr, logic mw, logic br, logic [2:0] f3, logic [31:0] pc);
      obs_t o;
      o.valid = v; o.in1 = in1; o.in2 = in2; o.aluop = op; o.invert = inv;
      o.rs2_data = r2d; o.rd = rd; o.regwrite = rw; o.memread = mr; o.memwrite = mw;
      o.branch = br; o.funct3 = f3; o.pc = pc;
      return o;
   endfunction

   function automatic obs_t sample();
      return mko(ex_valid, ex_alu_in1, ex_alu_in2, ex_aluop, ex_invert, ex_rs2_data, ex_rd,
                 ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_funct3, ex_pc);
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [31:0] fwd_model(logic [4:0] rs, logic [31:0] rf, stim_t s);
      if (rs == 5'd0) return 32'd0;
      if (s.exm_we && s.exm_rd == rs) return s.exm_res;
      if (s.mwb_we && s.mwb_rd == rs) return s.mwb_res;
      return rf;
   endfunction

   function automatic void model_uses(input logic [31:0] instr, output logic u1, output logic u2);
      u1 = 1'b0;
      u2 = 1'b0;
      case (instr[6:0])
         7'h33, 7'h23: begin u1 = 1'b1; u2 = 1'b1; end
         7'h63: if (instr[14:12] != 3'd2 && instr[14:12] != 3'd3) begin u1 = 1'b1; u2 = 1'b1; end
         7'h13, 7'h03, 7'h67: u1 = 1'b1;
         default: ;
      endcase
   endfunction

   function automatic obs_t model_issue(stim_t s);
      obs_t        o;
      logic [2:0]  f3;
      logic [31:0] a, b, imm_i, imm_s;
      logic        wr, u1, u2;
      o  = '0;
      f3 = s.instr[14:12];
      if (!s.idv || s.instr == NOP) return o;
      a     = fwd_model(s.instr[19:15], s.r1, s);
      b     = fwd_model(s.instr[24:20], s.r2, s);
      imm_i = 32'($signed(s.instr) >>> 20);
      imm_s = (32'($signed(s.instr) >>> 25) << 5) | {27'd0, s.instr[11:7]};
      model_uses(s.instr, u1, u2);
      wr = 1'b0;
      o.valid  = 1'b1;
      o.pc     = s.pc;
      o.funct3 = f3;
      case (s.instr[6:0])
         7'h33: begin
            o.in1 = a; o.in2 = b; o.aluop = f3; wr = 1'b1;
            o.invert = s.instr[30] && (f3 == 3'd0 || f3 == 3'd5);
         end
         7'h13: begin
            o.in1 = a; o.in2 = imm_i; o.aluop = f3; wr = 1'b1;
            o.invert = s.instr[30] && (f3 == 3'd5);
         end
         7'h03: begin o.in1 = a; o.in2 = imm_i; o.memread = 1'b1; wr = 1'b1; end
         7'h23: begin o.in1 = a; o.in2 = imm_s; o.memwrite = 1'b1; end
         7'h63: begin
            if (f3 == 3'd2 || f3 == 3'd3) return '0;
            o.in1 = a; o.in2 = b; o.branch = 1'b1;
            o.aluop  = (f3 < 3'd4) ? 3'd0 : ((f3 < 3'd6) ? 3'd2 : 3'd3);
            o.invert = (f3 < 3'd4);
         end
         7'h37: begin o.in1 = 32'd0; o.in2 = s.instr & 32'hFFFFF000; wr = 1'b1; o.funct3 = 3'd0; end
         7'h17: begin o.in1 = s.pc; o.in2 = s.instr & 32'hFFFFF000; wr = 1'b1; o.funct3 = 3'd0; end
         7'h6F: begin o.in1 = s.pc; o.in2 = 32'd4; wr = 1'b1; o.funct3 = 3'd0; end
         7'h67: begin o.in1 = s.pc; o.in2 = 32'd4; wr = 1'b1; end
         default: return '0;
      endcase
      o.rs2_data = u2 ? b : 32'd0;
      o.rd       = wr ? s.instr[11:7] : 5'd0;
      o.regwrite = wr && (s.instr[11:7] != 5'd0);
      return o;
   endfunction

   function automatic logic model_stall(stim_t s, obs_t ex);
      logic u1, u2;
      model_uses(s.instr, u1, u2);
      return !s.flush && s.idv && ex.valid && ex.memread && (ex.rd != 5'd0) &&
             ((u1 && s.instr[19:15] == ex.rd) || (u2 && s.instr[24:20] == ex.rd));
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check_obs(string name, obs_t act, obs_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: ex got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_bit(string name, logic act, logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: stall got %b want %b", name, act, exp);
      end
   endtask

   task automatic drive(stim_t s);
      id_valid = s.idv; id_instr = s.instr; id_pc = s.pc;
      rf_rs1_data = s.r1; rf_rs2_data = s.r2;
      exm_regwrite = s.exm_we; exm_rd = s.exm_rd; exm_result = s.exm_res;
      mwb_regwrite = s.mwb_we; mwb_rd = s.mwb_rd; mwb_result = s.mwb_res;
      flush = s.flush;
   endtask

   // Drive one cycle, check combinational stall, clock, then check ID/EX
   task automatic step(string name, stim_t s, obs_t exp_next, logic exp_stall);
      drive(s);
      #1;
      check_bit(name, stall, exp_stall);
      @(posedge clk);
      #1;
      check_obs(name, sample(), exp_next);
      mdl_ex = exp_next;
   endtask

   function automatic logic [6:0] pick_op(int k);
      case (k)
         0: return 7'h33;  1: return 7'h13;  2: return 7'h03;  3: return 7'h23;
         4: return 7'h63;  5: return 7'h37;  6: return 7'h17;  7: return 7'h6F;
         8: return 7'h67;  9: return 7'h7F;  default: return 7'h0B;
      endcase
   endfunction

   vec_t  vecs[16];
   stim_t s_lw, s_add, s_add2, s_sub;

   initial begin
      stim_t       s;
      obs_t        e;
      logic        st;
      logic [31:0] rnd;
      int          k;

      vecs[0]  = '{"sub",       mks(1, 32'h402081B3, 32'h40, 10, 3, 0, 0, 0, 0, 0, 0, 0),
                   mko(1, 10, 3, 0, 1, 3, 3, 1, 0, 0, 0, 0, 32'h40)};
      vecs[1]  = '{"fwd_exm_pri", mks(1, 32'h003182B3, 32'h44, 100, 200, 1, 3, 7, 1, 3, 9, 0),
                   mko(1, 7, 7, 0, 0, 7, 5, 1, 0, 0, 0, 0, 32'h44)};
      vecs[2]  = '{"fwd_x0",    mks(1, 32'h000002B3, 32'h48, 100, 200, 1, 0, 7, 1, 0, 9, 0),
                   mko(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 32'h48)};
      vecs[3]  = '{"bltu",      mks(1, 32'h0020E063, 32'h4C, 5, 6, 0, 0, 0, 0, 0, 0, 0),
                   mko(1, 5, 6, 3, 0, 6, 0, 0, 0, 0, 1, 6, 32'h4C)};
      vecs[4]  = '{"bne",       mks(1, 32'h00209063, 32'h50, 5, 6, 0, 0, 0, 0, 0, 0, 0),
                   mko(1, 5, 6, 0, 1, 6, 0, 0, 0, 0, 1, 1, 32'h50)};
      vecs[5]  = '{"auipc",     mks(1, 32'h12345397, 32'h100, 1, 2, 0, 0, 0, 0, 0, 0, 0),
                   mko(1, 32'h100, 32'h12345000, 0, 0, 0, 7, 1, 0, 0, 0, 0, 32'h100)};
      vecs[6]  = '{"addi_neg",  mks(1, 32'hFFF10093, 32'h54, 50, 2, 0, 0, 0, 0, 0, 0, 0),
                   mko(1, 50, 32'hFFFFFFFF, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h54)};
      vecs[7]  = '{"srai",      mks(1, 32'h40315093, 32'h58, 32'h80000000, 2, 0, 0, 0, 0, 0, 0, 0),
                   mko(1, 32'h80000000, 32'h403, 5, 1, 0, 1, 1, 0, 0, 0, 5, 32'h58)};
      vecs[8]  = '{"sw",        mks(1, 32'h0020A423, 32'h5C, 32'h1000, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0),
                   mko(1, 32'h1000, 8, 0, 0, 32'hDEAD, 0, 0, 0, 1, 0, 2, 32'h5C)};
      vecs[9]  = '{"unknown_op", mks(1, 32'h0000007F, 32'h60, 1, 2, 0, 0, 0, 0, 0, 0, 0), '0};
      vecs[10] = '{"nop_bubble", mks(1, NOP, 32'h64, 1, 2, 0, 0, 0, 0, 0, 0, 0), '0};
      vecs[11] = '{"id_invalid", mks(0, 32'h402081B3, 32'h68, 10, 3, 0, 0, 0, 0, 0, 0, 0), '0};
      vecs[12] = '{"jal",       mks(1, 32'h000000EF, 32'h200, 1, 2, 0, 0, 0, 0, 0, 0, 0),
                   mko(1, 32'h200, 4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h200)};
      vecs[13] = '{"lui_rd0",   mks(1, 32'hABCDE037, 32'h70, 1, 2, 0, 0, 0, 0, 0, 0, 0),
                   mko(1, 0, 32'hABCDE000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h70)};
      vecs[14] = '{"sltu_mwb",  mks(1, 32'h0020B433, 32'h74, 1, 2, 0, 0, 0, 1, 2, 32'h99, 0),
                   mko(1, 1, 32'h99, 3, 0, 32'h99, 8, 1, 0, 0, 0, 3, 32'h74)};
      vecs[15] = '{"flush_valid", mks(1, 32'h402081B3, 32'h78, 10, 3, 0, 0, 0, 0, 0, 0, 1), '0};

      s_lw   = mks(1, 32'h0000A203, 32'h300, 32'h1000, 32'h2, 0, 0, 0, 0, 0, 0, 0);
      s_add  = mks(1, 32'h00220333, 32'h304, 32'h55, 32'h66, 0, 0, 0, 0, 0, 0, 0);
      s_add2 = mks(1, 32'h00220333, 32'h304, 32'h55, 32'h66, 0, 0, 0, 1, 4, 32'h777, 0);
      s_sub  = mks(1, 32'h402081B3, 32'h400, 10, 3, 0, 0, 0, 0, 0, 0, 0);

      // Reset state, with a would-be load-use instruction presented
      reset = 1'b1;
      drive(s_add);
      repeat (2) @(posedge clk);
      #1;
      check_bit("reset_state", stall, 1'b0);
      check_obs("reset_state", sample(), '0);
      reset = 1'b0;
      mdl_ex = '0;

      // Directed table
      for (int i = 0; i < 16; i++) step(vecs[i].name, vecs[i].s, vecs[i].e, 1'b0);

      // Load-use: bubble, then re-issue with the loaded value from MEM/WB
      step("lw_issue", s_lw, mko(1, 32'h1000, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2, 32'h300), 1'b0);
      step("load_use_stall", s_add, '0, 1'b1);
      step("load_use_reissue", s_add2,
           mko(1, 32'h777, 32'h66, 0, 0, 32'h66, 6, 1, 0, 0, 0, 0, 32'h304), 1'b0);

      // Flush beats a stall-causing instruction
      step("lw_issue2", s_lw, mko(1, 32'h1000, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2, 32'h300), 1'b0);
      s = s_add;
      s.flush = 1'b1;
      step("flush_over_stall", s, '0, 1'b0);

      // Reset mid-stream with a load in EX and a dependent instruction waiting
      step("lw_issue3", s_lw, mko(1, 32'h1000, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2, 32'h300), 1'b0);
      reset = 1'b1;
      step("reset_mid", s_add, '0, 1'b0);
      reset = 1'b0;
      step("after_reset", s_sub, mko(1, 10, 3, 0, 1, 3, 3, 1, 0, 0, 0, 0, 32'h400), 1'b0);

      // Randomized stimulus against the model
      for (int n = 0; n < 600; n++) begin
         rnd = $urandom();
         k   = int'($urandom_range(0, 11));
         if (k == 11) s.instr = NOP;
         else s.instr = {rnd[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         rnd[14:12], 5'($urandom_range(0, 7)), pick_op(k)};
         s.idv     = ($urandom_range(0, 7) != 0);
         s.pc      = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
         s.r1      = $urandom();
         s.r2      = $urandom();
         s.exm_we  = $urandom_range(0, 1) == 1;
         s.exm_rd  = 5'($urandom_range(0, 7));
         s.exm_res = $urandom();
         s.mwb_we  = $urandom_range(0, 1) == 1;
         s.mwb_rd  = 5'($urandom_range(0, 7));
         s.mwb_res = $urandom();
         s.flush   = ($urandom_range(0, 9) == 0);
         st = model_stall(s, mdl_ex);
         e  = (s.flush || st) ? '0 : model_issue(s);
         step("rand", s, e, st);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
